tone_decoder: RTL
=================

# tone_decoder

Measures the period of an incoming square-wave tone and classifies it as one of the seven scale notes (1–7) produced by the team's buzzer tone generator. It is the receive end of that interface. Typical use is loopback verification of the buzzer drive or decoding an external tone line. It sits between an external or looped-back `tone_in` pin and downstream display/LED logic. It reports a stable note code only after several consecutive matching periods.

## Interface
- `PERIOD_1`, default 18'd190841: nominal period of note 1, in sys_clk cycles (50 MHz).
- `PERIOD_2`, default 18'd170069: nominal period of note 2.
- `PERIOD_3`, default 18'd151516: nominal period of note 3.
- `PERIOD_4`, default 18'd143267: nominal period of note 4.
- `PERIOD_5`, default 18'd127552: nominal period of note 5.
- `PERIOD_6`, default 18'd113637: nominal period of note 6.
- `PERIOD_7`, default 18'd101216: nominal period of note 7.
- `TOL`, default 18'd2000: symmetric match tolerance, in cycles.
- `MATCH_CNT`, default 3'd3: consecutive identical classifications required before reporting a note (1..7).
- `TIMEOUT`, default 18'd250000: cycles without a rising edge before declaring silence.
- `sys_clk` input 1: system clock, 50 MHz.
- `sys_rst_n` input 1: asynchronous active-low reset.
- `tone_in` input 1: asynchronous square-wave tone input.
- `note_code` output 3: current note; 0 means none, 1..7 means note.
- `note_valid` output 1: high while `note_code` is nonzero and locked.
- `note_strobe` output 1: one-cycle pulse whenever `note_code` changes.
- `period_out` output 18: last measured period, in cycles.

Reset is `sys_rst_n`, asynchronous, active-low; the clock is `sys_clk`.

## Operation
- **Input conditioning:** `tone_in` passes through a 2-flop synchronizer into a third history flop. `rise = sync2 & ~sync3`.
- **Period counter `per_cnt` (18 bit):**
  - Increments every cycle.
  - Cleared to 0 on `rise`.
  - Saturates and holds at `TIMEOUT`.
  - Measured period `P = per_cnt + 1` at `rise`. Edges every N cycles therefore yield P = N.
- **State machine:**
  - IDLE: no reference edge yet. Entered at reset and on timeout. On `rise` → ARMED; no measurement is taken.
  - ARMED: reference edge held. On `rise` → take measurement P, load `period_out <= P`, and classify next cycle. Stay in ARMED.
  - On timeout (`per_cnt == TIMEOUT`) from ARMED → IDLE.
- **Classification (registered, 1 cycle after measurement):**
  - `cand = k` if `|P − PERIOD_k| <= TOL`; the lowest k wins if ranges overlap.
  - Otherwise `cand = 0`.
  - Use 19-bit signed or compare-both-ways arithmetic; there is no wrap in the subtraction.
- **Run counter `run` (3 bit):**
  - If `cand != 0` and `cand == prev_cand`: `run <= min(run + 1, MATCH_CNT)`.
  - If `cand != 0` and differs from `prev_cand`: `run <= 1`.
  - If `cand == 0`: `run <= 0`.
  - `prev_cand <= cand` on every classification.
- **Output update (1 cycle after classification):**
  - If the updated `run == MATCH_CNT` and `cand != note_code`: load `note_code <= cand`, `note_valid <= 1`, and pulse `note_strobe`.
  - If `cand == 0` and `note_code != 0`: `note_code <= 0`, `note_valid <= 0`, and pulse `note_strobe`.
  - A nonzero `cand` that differs from `note_code` with `run < MATCH_CNT` leaves the outputs unchanged. This is the hysteresis during note changes.
- **Timeout:**
  - Entering IDLE forces `note_code <= 0`, `note_valid <= 0`, `run <= 0`, `prev_cand <= 0`.
  - `note_strobe` pulses only if `note_code` was nonzero.
  - `period_out` holds its value.
- **Simultaneous `rise` and timeout in the same cycle:** timeout is applied, then `rise` is taken as the new reference edge, so the state goes to ARMED with no measurement.

## Timing
- **Reset values:** `note_code` = 0, `note_valid` = 0, `note_strobe` = 0, `period_out` = 0. All internal registers are 0 and the state is IDLE.
- **Reset mid-operation:** outputs go to their reset values immediately (asynchronous). After release, the first `rise` only arms; no measurement is taken.
- **Edge detection:** `rise` asserts on the 3rd sys_clk edge after `tone_in` is first sampled high.
- **Measurement:** `period_out` updates on the same edge that `rise` is registered, i.e. the cycle `rise` is high is when capture occurs.
- **Pipeline:** classification follows 1 cycle after capture. `note_code`, `note_valid` and `note_strobe` follow 1 cycle after that.
- **Lock latency:** from the first rising edge of a clean tone, lock needs MATCH_CNT + 1 rising edges (1 reference edge plus MATCH_CNT measurements). Outputs then update 2 cycles after the last `rise`.
- **Timeout latency:** silence is declared exactly `TIMEOUT` cycles after the last `rise`. Outputs update on the next edge.
- **Strobe width:** `note_strobe` is exactly 1 cycle wide, and there is never more than one strobe per classification.

## Test plan
1. **Reset:** assert reset with `tone_in` toggling → all outputs 0. Release, then apply a 190841-cycle square wave → `note_code` = 1 and `note_valid` = 1 after the 4th rising edge plus 5 cycles. `note_strobe` fires exactly once.
2. **Note change:** locked on note 1, switch to period 127552 → `note_code` stays 1 for the first 2 new periods, becomes 5 on the 3rd, with one strobe. `period_out` = 127552.
3. **Tolerance boundary:** periods of 113637 ± 2000 → match 6. Periods of 113637 ± 2001 → `cand` = 0, and the outputs drop to 0/0 with a strobe if they were locked.
4. **Silence:** stop the tone while locked on note 3 → `note_valid` falls at exactly 250000 cycles after the last `rise` (+1 cycle) with one strobe. The next tone needs a reference edge plus 3 periods to relock.
5. **Glitch run:** send 2 periods of 170069, 1 period of 160000, then 3 periods of 170069 → no lock after the first two; lock to 2 only on the 3rd period after the glitch.
6. **Reset mid-lock:** pulse `sys_rst_n` low for 1 cycle while locked on note 7 → immediate 0 outputs and no strobe. Relock requires a full MATCH_CNT + 1 edges.

Source files
------------

// File: rtl/tone_decoder.sv
// Measures the tone_in period and reports a scale note after MATCH_CNT matching periods.
// Capture occurs on the cycle rise is high; classification takes 1 cycle and outputs 1 more. There is no backpressure.
module tone_decoder #(
    parameter logic [17:0] PERIOD_1  = 18'd190841,
    parameter logic [17:0] PERIOD_2  = 18'd170069,
    parameter logic [17:0] PERIOD_3  = 18'd151516,
    parameter logic [17:0] PERIOD_4  = 18'd143267,
    parameter logic [17:0] PERIOD_5  = 18'd127552,
    parameter logic [17:0] PERIOD_6  = 18'd113637,
    parameter logic [17:0] PERIOD_7  = 18'd101216,
    parameter logic [17:0] TOL       = 18'd2000,
    parameter logic [2:0]  MATCH_CNT = 3'd3,
    parameter logic [17:0] TIMEOUT   = 18'd250000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        tone_in,
    output logic [2:0]  note_code,
    output logic        note_valid,
    output logic        note_strobe,
    output logic [17:0] period_out
);

    typedef enum logic {S_IDLE, S_ARMED} state_t;

    localparam logic [17:0] PER [7] = '{PERIOD_1, PERIOD_2, PERIOD_3, PERIOD_4,
                                         PERIOD_5, PERIOD_6, PERIOD_7};

    state_t      state_q, state_d;
    logic [2:0]  sync_q;
    logic [17:0] per_cnt_q;
    logic        meas_vld_q, cls_vld_q;
    logic [2:0]  cand_q, prev_cand_q, run_q;
    logic [2:0]  cand_d, run_d;
    logic [3:0]  run_inc;
    logic [18:0] p_ext;
    logic        rise, timeout, to_evt, meas;

    assign rise    = sync_q[1] & ~sync_q[2];
    assign timeout = (per_cnt_q == TIMEOUT);

    always_comb begin
        state_d = state_q;
        meas    = 1'b0;
        to_evt  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rise) state_d = S_ARMED;
            end
            S_ARMED: begin
                // A rise coinciding with timeout becomes the new reference edge.
                if (timeout) begin
                    to_evt  = 1'b1;
                    state_d = rise ? S_ARMED : S_IDLE;
                end else if (rise) begin
                    meas = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        p_ext  = {1'b0, period_out};
        cand_d = 3'd0;
        // Scan from the top so the lowest matching note wins on overlap.
        for (int k = 6; k >= 0; k--) begin
            if ((p_ext + {1'b0, TOL} >= {1'b0, PER[k]}) &&
                (p_ext <= {1'b0, PER[k]} + {1'b0, TOL}))
                cand_d = 3'(k + 1);
        end
        run_inc = {1'b0, run_q} + 4'd1;
        if (cand_d == 3'd0)
            run_d = 3'd0;
        else if (cand_d == prev_cand_q)
            run_d = (run_inc >= {1'b0, MATCH_CNT}) ? MATCH_CNT : run_inc[2:0];
        else
            run_d = 3'd1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            sync_q      <= 3'd0;
            per_cnt_q   <= 18'd0;
            meas_vld_q  <= 1'b0;
            cls_vld_q   <= 1'b0;
            cand_q      <= 3'd0;
            prev_cand_q <= 3'd0;
            run_q       <= 3'd0;
            period_out  <= 18'd0;
            note_code   <= 3'd0;
            note_valid  <= 1'b0;
            note_strobe <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[1:0], tone_in};
            meas_vld_q  <= meas;
            note_strobe <= 1'b0;

            if (rise)
                per_cnt_q <= 18'd0;
            else if (!timeout)
                per_cnt_q <= per_cnt_q + 18'd1;

            if (meas)
                period_out <= per_cnt_q + 18'd1;

            if (to_evt) begin
                cls_vld_q   <= 1'b0;
                run_q       <= 3'd0;
                prev_cand_q <= 3'd0;
            end else begin
                cls_vld_q <= meas_vld_q;
                if (meas_vld_q) begin
                    cand_q      <= cand_d;
                    prev_cand_q <= cand_d;
                    run_q       <= run_d;
                end
            end

            if (to_evt) begin
                note_strobe <= (note_code != 3'd0);
                note_code   <= 3'd0;
                note_valid  <= 1'b0;
            end else if (cls_vld_q) begin
                // A differing candidate below MATCH_CNT leaves the current note in place.
                if (run_q == MATCH_CNT && cand_q != note_code) begin
                    note_code   <= cand_q;
                    note_valid  <= 1'b1;
                    note_strobe <= 1'b1;
                end else if (cand_q == 3'd0 && note_code != 3'd0) begin
                    note_code   <= 3'd0;
                    note_valid  <= 1'b0;
                    note_strobe <= 1'b1;
                end
            end
        end
    end

endmodule
